fa8b_rev_ctrl: RTL
==================

# fa8b_rev_ctrl

Sequencer for the dual-rail reversible 8-bit adder macro `fa8b_rev`. Accepts one add request at a time on a valid/ready port and runs four phases: forward evaluation (drive a, b, c0; sample s, c7), un-compute (drive s, c7, b back; sample a_b, c0_b), then return all rails to the null spacer. Returns the sum with rail-integrity and reversibility error flags. Sits between the PE datapath and the tristate pad/rail drivers wrapping the macro.

## Interface
- EVAL_CYC, default 4: cycles each rail phase is held (forward, backward); legal 1..255.
- SPACER_CYC, default 2: cycles all rails are held at spacer (both rails low) after un-compute; legal 1..255.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous and active-low.
- req_valid  in  1; req_ready  out  1; req_a  in  8; req_b  in  8; req_cin  in  1 — request port.
- rsp_valid  out  1; rsp_ready  in  1; rsp_sum  out  8; rsp_cout  out  1; rsp_err  out  2 (bit0 rail fault, bit1 reversibility mismatch) — response port.
- fwd_oe  out  1: enable for a*_f/a*_not_f and c0_f/c0_f_not drivers.
- b_oe  out  1: enable for b*/b*_not drivers.
- bwd_oe  out  1: enable for s*/s*_not and c7/c7_not drivers.
- fwd_a, fwd_a_n  out  8 each; fwd_b, fwd_b_n  out  8 each; fwd_c, fwd_c_n  out  1 each — forward rail values.
- bwd_s, bwd_s_n  out  8 each; bwd_c7, bwd_c7_n  out  1 each — backward rail values.
- sum_in, sum_n_in  in  8 each; cout_in, cout_n_in  in  1 each — sensed s*/c7 rails.
- ba_in, ba_n_in  in  8 each; bc_in, bc_n_in  in  1 each — sensed a*_b/c0_b rails.

## Operation
- States: IDLE, FWD, GAP, BWD, SPACER, RESP.
- IDLE: req_ready=1, all oe 0, all rail outputs 0. On req_valid&&req_ready latch a, b, cin; go FWD.
- FWD (EVAL_CYC cycles): fwd_oe=b_oe=1; fwd_a=a, fwd_a_n=~a, fwd_b=b, fwd_b_n=~b, fwd_c=cin, fwd_c_n=~cin. On the last cycle register sum_in, cout_in; rail fault if any pair sum_in[i]/sum_n_in[i] or cout_in/cout_n_in is not complementary.
- GAP (1 cycle): fwd_oe=0, fwd rails 0, b_oe stays 1, bwd_oe=0. Prevents contention on s/c7.
- BWD (EVAL_CYC cycles): b_oe=1, bwd_oe=1; bwd_s=captured sum, bwd_s_n=~sum, bwd_c7=cout, bwd_c7_n=~cout. On the last cycle sample ba_in, bc_in: rail fault if any pair non-complementary; reversibility mismatch if ba_in≠latched a or bc_in≠latched cin.
- SPACER (SPACER_CYC cycles): all oe 0, all rail outputs 0.
- RESP: rsp_valid=1, rsp_sum/rsp_cout/rsp_err stable until rsp_valid&&rsp_ready; then IDLE. req_ready=0 in every state except IDLE.
- Error bits are sticky across the transaction, cleared on next accept. Sum/cout always taken from true rails, even on fault.
- Phase counter is 8 bits, loaded at entry, no wrap.

## Timing
- Reset (rst_n low at an edge): state IDLE, every output 0 including req_ready; req_ready=1 from the first edge with rst_n high.
- Reset mid-transaction: at that edge all oe and rails drop to 0, transaction discarded, no response.
- Accept edge = cycle 0. FWD cycles 1..EVAL_CYC; GAP one cycle; BWD EVAL_CYC cycles; SPACER SPACER_CYC cycles; rsp_valid first high 2·EVAL_CYC+SPACER_CYC+2 cycles after accept (12 at defaults).
- fwd_oe and bwd_oe never high in the same cycle; fwd_oe high → all driven pairs complementary.
- No new request accepted in the cycle the response completes; next accept earliest in the following IDLE cycle.

## Test plan
- Reset: rst_n low 3 cycles mid-idle → all outputs 0; req_ready=1 one cycle after release.
- Ideal macro model, a=0x5A, b=0x33, cin=0 → rsp_sum=0x8D, rsp_cout=0, rsp_err=0, rsp_valid 12 cycles after accept; fwd_oe/bwd_oe never overlap.
- a=0xFF, b=0x01, cin=1 with rsp_ready low 5 cycles → rsp_sum=0x01, rsp_cout=1, outputs stable while stalled, req_ready=0 throughout.
- Force sum_n_in[3]=sum_in[3] during FWD sample, a=0x5A, b=0x33 → rsp_err=2'b01, rsp_sum still 0x8D.
- Model returns ba_in=0x00 (complementary rails) instead of 0x5A → rsp_err=2'b10.
- rst_n low for one edge during BWD → next cycle all oe 0, rails 0, no rsp_valid; subsequent request completes normally.

Source files
------------

// File: rtl/fa8b_rev_ctrl.sv
// Phase sequencer for the dual-rail reversible 8-bit adder macro: forward evaluate,
// un-compute, spacer, then return the sum with rail-fault / reversibility flags.
module fa8b_rev_ctrl #(
  parameter int unsigned EVAL_CYC   = 4,
  parameter int unsigned SPACER_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic       req_cin,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_sum,
  output logic       rsp_cout,
  output logic [1:0] rsp_err,
  output logic       fwd_oe,
  output logic       b_oe,
  output logic       bwd_oe,
  output logic [7:0] fwd_a,
  output logic [7:0] fwd_a_n,
  output logic [7:0] fwd_b,
  output logic [7:0] fwd_b_n,
  output logic       fwd_c,
  output logic       fwd_c_n,
  output logic [7:0] bwd_s,
  output logic [7:0] bwd_s_n,
  output logic       bwd_c7,
  output logic       bwd_c7_n,
  input  logic [7:0] sum_in,
  input  logic [7:0] sum_n_in,
  input  logic       cout_in,
  input  logic       cout_n_in,
  input  logic [7:0] ba_in,
  input  logic [7:0] ba_n_in,
  input  logic       bc_in,
  input  logic       bc_n_in
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FWD    = 3'd1,
    GAP    = 3'd2,
    BWD    = 3'd3,
    SPACER = 3'd4,
    RESP   = 3'd5
  } state_t;

  localparam logic [7:0] L_EVAL   = 8'(EVAL_CYC);
  localparam logic [7:0] L_SPACER = 8'(SPACER_CYC);

  function automatic logic pair_bad8(input logic [7:0] t, input logic [7:0] f);
    return |(~(t ^ f));
  endfunction

  function automatic logic pair_bad1(input logic t, input logic f);
    return ~(t ^ f);
  endfunction

  state_t     r_state, w_next;
  logic [7:0] r_cnt, w_cnt_next;
  logic       w_accept, w_rsp_done, w_last;
  logic [7:0] r_a, r_b, r_sum;
  logic       r_cin, r_cout;
  logic [1:0] r_err;
  logic [7:0] w_a_nx, w_b_nx;
  logic       w_c_nx, w_b_drive;
  logic       w_fwd_fault, w_bwd_fault, w_rev_mis;

  logic       r_req_ready, r_rsp_valid, r_rsp_cout, r_fwd_oe, r_b_oe, r_bwd_oe;
  logic [7:0] r_rsp_sum, r_fwd_a, r_fwd_a_n, r_fwd_b, r_fwd_b_n, r_bwd_s, r_bwd_s_n;
  logic [1:0] r_rsp_err;
  logic       r_fwd_c, r_fwd_c_n, r_bwd_c7, r_bwd_c7_n;

  assign w_accept   = req_valid && r_req_ready && (r_state == IDLE);
  assign w_rsp_done = r_rsp_valid && rsp_ready;
  assign w_last     = (r_cnt <= 8'd1);

  // Operands seen by the rail drivers: the request itself on the accept edge, latched copy after
  assign w_a_nx    = w_accept ? req_a   : r_a;
  assign w_b_nx    = w_accept ? req_b   : r_b;
  assign w_c_nx    = w_accept ? req_cin : r_cin;
  assign w_b_drive = (w_next == FWD) || (w_next == GAP) || (w_next == BWD);

  assign w_fwd_fault = pair_bad8(sum_in, sum_n_in) | pair_bad1(cout_in, cout_n_in);
  assign w_bwd_fault = pair_bad8(ba_in, ba_n_in)   | pair_bad1(bc_in, bc_n_in);
  assign w_rev_mis   = (ba_in != r_a) || (bc_in != r_cin);

  // Next-state and phase counter; the counter is reloaded on entry and never wraps
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next     = FWD;
          w_cnt_next = L_EVAL;
        end else begin
          w_next = IDLE;
        end
      end
      FWD: begin
        if (w_last) w_next = GAP;
        else        w_cnt_next = r_cnt - 8'd1;
      end
      GAP: begin
        w_next     = BWD;
        w_cnt_next = L_EVAL;
      end
      BWD: begin
        if (w_last) begin
          w_next     = SPACER;
          w_cnt_next = L_SPACER;
        end else begin
          w_cnt_next = r_cnt - 8'd1;
        end
      end
      SPACER: begin
        if (w_last) w_next = RESP;
        else        w_cnt_next = r_cnt - 8'd1;
      end
      RESP: begin
        if (w_rsp_done) w_next = IDLE;
        else            w_next = RESP;
      end
      default: begin
        w_next     = IDLE;
        w_cnt_next = 8'd0;
      end
    endcase
  end

  // State register and registered outputs decoded from the upcoming state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 8'd0;
      r_req_ready <= 1'b0;
      r_fwd_oe    <= 1'b0;
      r_b_oe      <= 1'b0;
      r_bwd_oe    <= 1'b0;
      r_fwd_a     <= 8'h00;
      r_fwd_a_n   <= 8'h00;
      r_fwd_b     <= 8'h00;
      r_fwd_b_n   <= 8'h00;
      r_fwd_c     <= 1'b0;
      r_fwd_c_n   <= 1'b0;
      r_bwd_s     <= 8'h00;
      r_bwd_s_n   <= 8'h00;
      r_bwd_c7    <= 1'b0;
      r_bwd_c7_n  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_sum   <= 8'h00;
      r_rsp_cout  <= 1'b0;
      r_rsp_err   <= 2'b00;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt_next;
      r_req_ready <= (w_next == IDLE);
      r_fwd_oe    <= (w_next == FWD);
      r_b_oe      <= w_b_drive;
      r_bwd_oe    <= (w_next == BWD);
      r_fwd_a     <= (w_next == FWD) ? w_a_nx  : 8'h00;
      r_fwd_a_n   <= (w_next == FWD) ? ~w_a_nx : 8'h00;
      r_fwd_b     <= w_b_drive ? w_b_nx  : 8'h00;
      r_fwd_b_n   <= w_b_drive ? ~w_b_nx : 8'h00;
      r_fwd_c     <= (w_next == FWD) ? w_c_nx  : 1'b0;
      r_fwd_c_n   <= (w_next == FWD) ? ~w_c_nx : 1'b0;
      r_bwd_s     <= (w_next == BWD) ? r_sum   : 8'h00;
      r_bwd_s_n   <= (w_next == BWD) ? ~r_sum  : 8'h00;
      r_bwd_c7    <= (w_next == BWD) ? r_cout  : 1'b0;
      r_bwd_c7_n  <= (w_next == BWD) ? ~r_cout : 1'b0;
      r_rsp_valid <= (w_next == RESP);
      r_rsp_sum   <= (w_next == RESP) ? r_sum  : 8'h00;
      r_rsp_cout  <= (w_next == RESP) ? r_cout : 1'b0;
      r_rsp_err   <= (w_next == RESP) ? r_err  : 2'b00;
    end
  end

  // Operand latch, sense-rail capture and sticky error flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a    <= 8'h00;
      r_b    <= 8'h00;
      r_cin  <= 1'b0;
      r_sum  <= 8'h00;
      r_cout <= 1'b0;
      r_err  <= 2'b00;
    end else if (w_accept) begin
      r_a   <= req_a;
      r_b   <= req_b;
      r_cin <= req_cin;
      r_err <= 2'b00;
    end else if ((r_state == FWD) && w_last) begin
      r_sum    <= sum_in;
      r_cout   <= cout_in;
      r_err[0] <= r_err[0] | w_fwd_fault;
    end else if ((r_state == BWD) && w_last) begin
      r_err <= r_err | {w_rev_mis, w_bwd_fault};
    end else begin
      r_err <= r_err;
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_cout  = r_rsp_cout;
  assign rsp_err   = r_rsp_err;
  assign fwd_oe    = r_fwd_oe;
  assign b_oe      = r_b_oe;
  assign bwd_oe    = r_bwd_oe;
  assign fwd_a     = r_fwd_a;
  assign fwd_a_n   = r_fwd_a_n;
  assign fwd_b     = r_fwd_b;
  assign fwd_b_n   = r_fwd_b_n;
  assign fwd_c     = r_fwd_c;
  assign fwd_c_n   = r_fwd_c_n;
  assign bwd_s     = r_bwd_s;
  assign bwd_s_n   = r_bwd_s_n;
  assign bwd_c7    = r_bwd_c7;
  assign bwd_c7_n  = r_bwd_c7_n;

endmodule
